// File: rtl/uart_rx_data40_pkg.sv
// rtl/uart_rx_data40_pkg.sv - shared baud codes, bit-period table and state encodings
package uart_rx_data40_pkg;

  localparam int CLK_FREQ = 50_000_000;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;
  localparam logic [2:0] BAUD_230400 = 3'd5;
  localparam logic [2:0] BAUD_460800 = 3'd6;
  localparam logic [2:0] BAUD_921600 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DONE
  } asm_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Clk cycles per UART bit for each baud code (truncated division).
  function automatic logic [15:0] bit_period(input logic [2:0] code);
    case (code)
      BAUD_9600:   return 16'(CLK_FREQ / 9600);
      BAUD_19200:  return 16'(CLK_FREQ / 19200);
      BAUD_38400:  return 16'(CLK_FREQ / 38400);
      BAUD_57600:  return 16'(CLK_FREQ / 57600);
      BAUD_115200: return 16'(CLK_FREQ / 115200);
      BAUD_230400: return 16'(CLK_FREQ / 230400);
      BAUD_460800: return 16'(CLK_FREQ / 460800);
      default:     return 16'(CLK_FREQ / 921600);
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_data40_if.sv
// rtl/uart_rx_data40_if.sv - serial input and assembled-frame outputs of the receive assembler
interface uart_rx_data40_if #(
  parameter int BYTES = 5
);
  logic                 uart_rx;
  logic [8*BYTES-1:0]   Data40;
  logic                 Rx_Done;
  logic                 Frame_Err;
  logic                 Busy;

  modport master (output uart_rx, input Data40, Rx_Done, Frame_Err, Busy);
  modport slave  (input uart_rx, output Data40, Rx_Done, Frame_Err, Busy);
endinterface

// File: rtl/uart_rx_data40_byte_rx.sv
// rtl/uart_rx_data40_byte_rx.sv - 8N1 byte receiver with synchronizer and stop-bit check
module uart_rx_data40_byte_rx
  import uart_rx_data40_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [2:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] Data,
  output logic       rx_done
);

  logic [1:0]  sync_q;
  logic        prev_q;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic [15:0] period;
  logic [15:0] half;
  logic        rx_s;

  assign period  = bit_period(baud_set);
  assign half    = {1'b0, period[15:1]};
  assign rx_s    = sync_q[1];
  assign Data    = data_q;
  assign rx_done = done_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], uart_rx};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // A falling edge is required, so a line held low after a bad stop bit is not a start.
        if (prev_q && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == half - 16'd1) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == period - 16'd1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == period - 16'd1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s) begin
            data_d = shift_q;
            done_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx_data40.sv
// rtl/uart_rx_data40.sv - multi-byte UART receive assembler with inter-byte timeout
module uart_rx_data40
  import uart_rx_data40_pkg::*;
#(
  parameter int         BYTES          = 5,
  parameter logic [2:0] BAUD_SET       = 3'd4,
  parameter int         TIMEOUT_CYCLES = 10000
) (
  input  logic              Clk,
  input  logic              Reset_n,
  uart_rx_data40_if.slave   bus
);

  localparam int W     = 8 * BYTES;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]       byte_data;
  logic             byte_done;

  asm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [W-1:0]     stage_q, stage_d;
  logic [W-1:0]     data_q, data_d;
  logic             rx_done_q, rx_done_d;
  logic             frame_err_q, frame_err_d;

  logic [CNT_W-1:0] slot;
  logic [W-1:0]     merged;
  logic             last;
  logic             accept;

  uart_rx_data40_byte_rx u_byte_rx (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .baud_set (BAUD_SET),
    .uart_rx  (bus.uart_rx),
    .Data     (byte_data),
    .rx_done  (byte_done)
  );

  assign bus.Data40    = data_q;
  assign bus.Rx_Done   = rx_done_q;
  assign bus.Frame_Err = frame_err_q;
  assign bus.Busy      = (state_q == ST_COLLECT);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      to_q        <= '0;
      stage_q     <= '0;
      data_q      <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      stage_q     <= stage_d;
      data_q      <= data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // The final byte is merged straight into Data40 so it lands one Clk after its strobe.
  always_comb begin
    slot                 = (state_q == ST_COLLECT) ? cnt_q : '0;
    merged               = stage_q;
    merged[8*slot +: 8]  = byte_data;
    last                 = (int'(slot) == BYTES - 1);
    accept               = byte_done && (state_q != ST_DONE);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    stage_d     = stage_q;
    data_d      = data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        to_d  = '0;
      end
      ST_COLLECT: begin
        to_d = to_q + 1'b1;
        if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          to_d        = '0;
          frame_err_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // A byte arriving on the expiry cycle overrides the timeout.
    if (accept) begin
      to_d        = '0;
      frame_err_d = 1'b0;
      if (last) begin
        data_d    = merged;
        rx_done_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_DONE;
      end else begin
        stage_d   = merged;
        cnt_d     = slot + 1'b1;
        state_d   = ST_COLLECT;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_data40.sv
// tb/tb_uart_rx_data40.sv - directed bench for the multi-byte UART receive assembler
module tb_uart_rx_data40;

  // Fastest baud code and a proportionally shorter timeout keep the run short.
  localparam int BIT = 54;
  localparam int TMO = 2000;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #10 Clk = ~Clk;

  uart_rx_data40_if #(.BYTES(5)) bus ();

  uart_rx_data40 #(
    .BYTES          (5),
    .BAUD_SET       (3'd7),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  int   n_err  = 0;
  int   since_bd = 0;
  logic bd_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset_n) begin
      since_bd = 0;
      bd_prev  = 1'b0;
    end else begin
      if (dut.byte_done) since_bd = 0;
      else since_bd++;
      if (bus.Rx_Done) begin
        n_done++;
        check("rx_done_latency", 64'(bd_prev), 64'd1);
      end
      if (bus.Frame_Err) begin
        n_err++;
        check("frame_err_latency", 64'(since_bd), 64'(TMO + 1));
      end
      if (bus.Rx_Done || bus.Frame_Err)
        check("done_err_exclusive", 64'(bus.Rx_Done & bus.Frame_Err), 64'd0);
      bd_prev = dut.byte_done;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    bus.uart_rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      wait_clks(BIT);
    end
    bus.uart_rx = stop_ok;
    wait_clks(BIT);
    if (!stop_ok) begin
      bus.uart_rx = 1'b1;
      wait_clks(BIT);
    end
  endtask

  task automatic send_frame(input logic [39:0] w, input int gap, input int bad_idx);
    for (int k = 0; k < 5; k++) begin
      send_byte(w[8*k +: 8], k != bad_idx);
      if (gap > 0 && k < 4) wait_clks(gap);
    end
    wait_clks(5);
  endtask

  task automatic clear_counts();
    n_done = 0;
    n_err  = 0;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.uart_rx = 1'b1;
    Reset_n = 1'b0;
    wait_clks(4);
    check("rst_data40", 64'(bus.Data40), 64'd0);
    check("rst_rx_done", 64'(bus.Rx_Done), 64'd0);
    check("rst_frame_err", 64'(bus.Frame_Err), 64'd0);
    check("rst_busy", 64'(bus.Busy), 64'd0);
    Reset_n = 1'b1;
    wait_clks(4);

    // 1: single frame
    clear_counts();
    send_frame(40'h5544332211, 0, 9);
    check("t1_data", 64'(bus.Data40), 64'h5544332211);
    check("t1_done_cnt", 64'(n_done), 64'd1);
    check("t1_err_cnt", 64'(n_err), 64'd0);
    check("t1_busy", 64'(bus.Busy), 64'd0);

    // 2: two frames back-to-back
    clear_counts();
    send_frame(40'hF0E0D0C0B0, 0, 9);
    send_frame(40'h0504030201, 0, 9);
    check("t2_done_cnt", 64'(n_done), 64'd2);
    check("t2_data", 64'(bus.Data40), 64'h0504030201);

    // 3: partial frame then timeout, then recovery
    clear_counts();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    wait_clks(5);
    check("t3_busy_partial", 64'(bus.Busy), 64'd1);
    check("t3_data_partial", 64'(bus.Data40), 64'h0504030201);
    wait_clks(2500);
    check("t3_err_cnt", 64'(n_err), 64'd1);
    check("t3_done_cnt", 64'(n_done), 64'd0);
    check("t3_busy_after", 64'(bus.Busy), 64'd0);
    check("t3_data_kept", 64'(bus.Data40), 64'h0504030201);
    send_frame(40'hDEADBEEF01, 0, 9);
    check("t3_recover_data", 64'(bus.Data40), 64'hDEADBEEF01);
    check("t3_recover_done", 64'(n_done), 64'd1);

    // 4: asynchronous reset mid-frame
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_clks(5);
    check("t4_busy_before", 64'(bus.Busy), 64'd1);
    #3 Reset_n = 1'b0;
    #1;
    check("t4_rst_data40", 64'(bus.Data40), 64'd0);
    check("t4_rst_busy", 64'(bus.Busy), 64'd0);
    check("t4_rst_flags", 64'({bus.Rx_Done, bus.Frame_Err}), 64'd0);
    wait_clks(3);
    Reset_n = 1'b1;
    wait_clks(3);
    clear_counts();
    send_frame(40'h5A5A5A5A5A, 0, 9);
    check("t4_data", 64'(bus.Data40), 64'h5A5A5A5A5A);
    check("t4_done_cnt", 64'(n_done), 64'd1);

    // 5: long gaps below the timeout
    clear_counts();
    send_frame(40'h8877665544, 1200, 9);
    check("t5_data", 64'(bus.Data40), 64'h8877665544);
    check("t5_done_cnt", 64'(n_done), 64'd1);
    check("t5_err_cnt", 64'(n_err), 64'd0);

    // 6: bad stop bit on byte 2, then recovery
    clear_counts();
    send_frame(40'hC4C3C2C1C0, 0, 2);
    wait_clks(2500);
    check("t6_done_cnt", 64'(n_done), 64'd0);
    check("t6_err_cnt", 64'(n_err), 64'd1);
    check("t6_data_kept", 64'(bus.Data40), 64'h8877665544);
    send_frame(40'h123456789A, 0, 9);
    check("t6_recover_data", 64'(bus.Data40), 64'h123456789A);
    check("t6_recover_done", 64'(n_done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
